// File: rtl/conv_sched_ctrl.sv
// Sequencing controller for the 3-D convolution address generator: paces the generator against
// MAC back-pressure, tags beats with partial-sum control and drains. Option: CONV_SCHED_PERF_EN.
module conv_sched_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DATA_HEIGHT   = 35,
    parameter int unsigned DATA_WIDTH    = 35,
    parameter int unsigned DATA_DEPTH    = 1,
    parameter int unsigned KERNAL_HEIGHT = 5,
    parameter int unsigned KERNAL_WIDTH  = 5,
    parameter int unsigned PIPE_LAT      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mac_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  gen_enable,
    output logic                  gen_pause,
    output logic                  addr_valid,
    output logic [ADDR_WIDTH-1:0] anchor_idx,
    output logic [7:0]            depth_idx,
    output logic                  psum_first,
    output logic                  psum_last,
    output logic [31:0]           stall_cycles
);

    localparam int unsigned N = (DATA_WIDTH - KERNAL_WIDTH + 1) *
                                (DATA_HEIGHT - KERNAL_HEIGHT + 1);
    localparam logic [ADDR_WIDTH-1:0] AnchorLast = ADDR_WIDTH'(N - 1);
    localparam logic [7:0]            DepthLast  = 8'(DATA_DEPTH - 1);
    localparam logic [3:0]            DrainLast  = (PIPE_LAT == 0) ? 4'd0 : 4'(PIPE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic                  gen_enable_q, gen_enable_d;
    logic [ADDR_WIDTH-1:0] anchor_q, anchor_d;
    logic [7:0]            depth_q, depth_d;
    logic [3:0]            drain_q, drain_d;

    logic in_run;
    logic xfer;
    logic at_anchor_last;
    logic last_xfer;

    assign in_run         = (state_q == StRun);
    assign xfer           = in_run & mac_ready;
    assign at_anchor_last = (anchor_q == AnchorLast);
    assign last_xfer      = at_anchor_last & (depth_q == DepthLast);

    always_comb begin
        state_d      = state_q;
        gen_enable_d = gen_enable_q;
        anchor_d     = anchor_q;
        depth_d      = depth_q;
        drain_d      = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StRun;
                    gen_enable_d = 1'b1;
                    anchor_d     = '0;
                    depth_d      = '0;
                end
            end
            StRun: begin
                if (xfer) begin
                    if (last_xfer) begin
                        // Indices return to 0 so they track the generator's wrapped counters.
                        gen_enable_d = 1'b0;
                        anchor_d     = '0;
                        depth_d      = '0;
                        drain_d      = '0;
                        state_d      = (PIPE_LAT == 0) ? StDone : StDrain;
                    end else if (at_anchor_last) begin
                        anchor_d = '0;
                        depth_d  = depth_q + 8'd1;
                    end else begin
                        anchor_d = anchor_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gen_enable_q <= 1'b0;
            anchor_q     <= '0;
            depth_q      <= '0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            gen_enable_q <= gen_enable_d;
            anchor_q     <= anchor_d;
            depth_q      <= depth_d;
            drain_q      <= drain_d;
        end
    end

    assign busy       = in_run | (state_q == StDrain);
    assign done       = (state_q == StDone);
    assign gen_enable = gen_enable_q;
    assign gen_pause  = ~xfer;
    assign addr_valid = in_run;
    assign anchor_idx = anchor_q;
    assign depth_idx  = depth_q;
    assign psum_first = in_run & (depth_q == 8'd0);
    assign psum_last  = in_run & (depth_q == DepthLast);

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == StIdle) && start) begin
            stall_d = '0;
        end else if (in_run && !mac_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
